// File: rtl/sa_pkg.sv
// Shared definitions for the spatial-array move-buffer channel.
package sa_pkg;

  localparam int SA_DATA_WIDTH      = 32;
  localparam int SA_MOVE_BUFF_DEPTH = 16;

  // Complex data is interleaved in memory: real part first, imaginary part next.
  localparam int REAL_OFFSET = 0;
  localparam int IMAG_OFFSET = 1;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_FLUSH  = 2'd2
  } feed_state_e;

  // Word offset of one half of an interleaved complex value.
  function automatic int cplx_offset(input logic imag);
    return imag ? IMAG_OFFSET : REAL_OFFSET;
  endfunction

endpackage

// File: rtl/sa_weight_ram.sv
// Simple dual-port weight store: one write port, one read port, registered read data.
module sa_weight_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 64,
  parameter int ADDR_W     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Host write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port with one cycle of latency; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sa_move_feeder.sv
// Transmit side of the move-buffer channel: streams stored weight sets into a column,
// one word per cycle, as bursts of MOVE_BUFF_DEPTH contiguous words.
module sa_move_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH      = SA_DATA_WIDTH,
  parameter int MOVE_BUFF_DEPTH = SA_MOVE_BUFF_DEPTH,
  parameter int NUM_SETS        = 4,
  parameter int MAX_BURSTS      = 16,
  parameter int ADDR_W          = $clog2(NUM_SETS * MOVE_BUFF_DEPTH),
  parameter int SET_W           = $clog2(NUM_SETS),
  parameter int BCNT_W          = $clog2(MAX_BURSTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [SET_W-1:0]      set_sel,
  input  logic [BCNT_W-1:0]     burst_cnt,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] move_buff_out,
  output logic                  move_buff_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);

  localparam int WORD_W = $clog2(MOVE_BUFF_DEPTH);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(MOVE_BUFF_DEPTH - 1);
  localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(NUM_SETS - 1);

  feed_state_e           state_q, state_d;
  logic [WORD_W-1:0]     word_q, word_d;     // next word index to issue
  logic [SET_W-1:0]      set_q, set_d;       // set of the next word to issue
  logic [BCNT_W-1:0]     bursts_q, bursts_d; // bursts not yet fully issued
  logic                  iss_vld_q, iss_vld_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_err_q;
  logic                  rd_vld_q;
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  ram_we_s;
  logic [BCNT_W-1:0]     cmd_bursts_s;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [SET_W-1:0]  s,
                                                   input logic [WORD_W-1:0] w);
    return ADDR_W'(s) * ADDR_W'(MOVE_BUFF_DEPTH) + ADDR_W'(w);
  endfunction

  function automatic logic [SET_W-1:0] next_set(input logic [SET_W-1:0] s);
    return (s == LAST_SET) ? '0 : s + SET_W'(1);
  endfunction

  // Host writes land only while idle so a burst never sees its data change.
  assign ram_we_s     = wr_en && (state_q == FEED_IDLE);
  assign cmd_bursts_s = (burst_cnt > BCNT_W'(MAX_BURSTS)) ? BCNT_W'(MAX_BURSTS) : burst_cnt;

  sa_weight_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (NUM_SETS * MOVE_BUFF_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we_s),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (iss_vld_q),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data_s)
  );

  // Command FSM: accepts a command, issues one read per non-held cycle, then drains.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    set_d     = set_q;
    bursts_d  = bursts_q;
    iss_vld_d = 1'b0;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (start && (burst_cnt != '0)) begin
          state_d  = FEED_STREAM;
          busy_d   = 1'b1;
          set_d    = set_sel;
          bursts_d = cmd_bursts_s;
          if (!hold) begin
            // The accepting edge already issues word 0.
            iss_vld_d = 1'b1;
            addr_d    = word_addr(set_sel, '0);
            word_d    = WORD_W'(1);
          end else begin
            word_d    = '0;
          end
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      FEED_STREAM: begin
        if (!hold) begin
          iss_vld_d = 1'b1;
          addr_d    = word_addr(set_q, word_q);
          if (word_q == LAST_WORD) begin
            word_d   = '0;
            set_d    = next_set(set_q);
            bursts_d = bursts_q - BCNT_W'(1);
            if (bursts_q == BCNT_W'(1)) begin
              state_d = FEED_FLUSH;
            end else begin
              state_d = FEED_STREAM;
            end
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end else begin
          iss_vld_d = 1'b0;
        end
      end
      FEED_FLUSH: begin
        // Leave once the final word sits alone in the output register.
        if (out_vld_q && !rd_vld_q && !iss_vld_q) begin
          state_d = FEED_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FEED_FLUSH;
        end
      end
      default: begin
        state_d = FEED_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and issue-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FEED_IDLE;
      word_q    <= '0;
      set_q     <= '0;
      bursts_q  <= '0;
      iss_vld_q <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      set_q     <= set_d;
      bursts_q  <= bursts_d;
      iss_vld_q <= iss_vld_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Read-valid tracking and output register; data holds while no word is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_vld_q  <= iss_vld_q;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        out_q <= rd_data_s;
      end
    end
  end

  // Sticky flag for host writes dropped while a command is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_q | (wr_en & busy_q);
    end
  end

  assign move_buff_out       = out_q;
  assign move_buff_out_valid = out_vld_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign wr_err              = wr_err_q;

endmodule

// File: tb/tb_sa_move_feeder.sv
// Self-checking bench for sa_move_feeder: table of commands plus directed corner sequences,
// each cycle compared with a word-stream model built from the memory image.
module tb_sa_move_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NSETS = 4;
  localparam int MAXB  = 16;
  localparam int AW    = $clog2(NSETS * DEPTH);
  localparam int SW    = $clog2(NSETS);
  localparam int BW    = $clog2(MAXB + 1);
  localparam int MAXE  = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [SW-1:0] set_sel = '0;
  logic [BW-1:0] burst_cnt = '0;
  logic          hold = 1'b0;
  logic [DW-1:0] move_buff_out;
  logic          move_buff_out_valid;
  logic          busy;
  logic          done;
  logic          wr_err;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_mem [NSETS*DEPTH];
  logic          exp_wr_err = 1'b0;

  typedef struct {
    int          prep;      // 1: rewrite word0 of set n to float(n) first
    int          set_s;
    int          nb;
    int          hmode;     // 0 none, 1 random, 2 window [hfrom, hfrom+hlen)
    int          hfrom;
    int          hlen;
    int          inj;       // edge of start+write injection, 0 = none
    int          exp_words;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  sa_move_feeder #(
    .DATA_WIDTH (DW), .MOVE_BUFF_DEPTH (DEPTH), .NUM_SETS (NSETS), .MAX_BURSTS (MAXB)
  ) dut (
    .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start), .set_sel (set_sel), .burst_cnt (burst_cnt), .hold (hold),
    .move_buff_out (move_buff_out), .move_buff_out_valid (move_buff_out_valid),
    .busy (busy), .done (done), .wr_err (wr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE754 single encoding of a small non-negative integer.
  function automatic logic [31:0] f32(input int v);
    int         e;
    logic [22:0] m;
    if (v == 0) return 32'h0000_0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 23'((v - (1 << e)) << (23 - e));
    return {1'b0, 8'(127 + e), m};
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Run one command from a negedge; predicts valid/data/busy/done/wr_err every cycle.
  task automatic run_cmd(input int s0, input int nb, input int hmode, input int hfrom,
                         input int hlen, input int inj, output int nwords, output logic [31:0] first);
    int   total, issued, last_e, e, k;
    int   iss_word [MAXE];
    logic hold_e, ev, fin;
    total = nb * DEPTH; issued = 0; last_e = -1; nwords = 0; first = '0; fin = 1'b0;
    for (e = 0; e < MAXE; e++) begin
      hold_e = 1'b0;
      if (hmode == 1) hold_e = ($urandom_range(0, 3) == 0);
      else if (hmode == 2) hold_e = (e >= hfrom && e < hfrom + hlen);
      hold  = hold_e;
      start = (e == 0) || (inj != 0 && e == inj);
      if (e == 0) begin
        set_sel = SW'(s0); burst_cnt = BW'(nb);
      end else begin
        set_sel = SW'($urandom); burst_cnt = BW'($urandom_range(1, MAXB));
      end
      wr_en   = (inj != 0 && e == inj);
      wr_addr = '0;
      wr_data = 32'hDEAD_BEEF;
      if (issued < total && !hold_e) begin
        iss_word[e] = issued;
        issued++;
        if (issued == total) last_e = e;
      end else begin
        iss_word[e] = -1;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (inj != 0 && e == inj) exp_wr_err = 1'b1;
      ev = (e >= 2) && (iss_word[(e >= 2) ? e - 2 : 0] >= 0);
      chk("valid", {31'd0, move_buff_out_valid}, {31'd0, ev});
      if (ev && move_buff_out_valid) begin
        k = iss_word[e - 2];
        chk("data", move_buff_out, model_mem[((s0 + k / DEPTH) % NSETS) * DEPTH + k % DEPTH]);
        if (nwords == 0) first = move_buff_out;
        nwords++;
      end
      chk("busy", {31'd0, busy}, {31'd0, !(last_e >= 0 && e >= last_e + 3)});
      chk("done", {31'd0, done}, {31'd0, (last_e >= 0 && e == last_e + 3)});
      chk("wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
      if (last_e >= 0 && e == last_e + 3) begin
        fin = 1'b1;
        break;
      end
    end
    hold = 1'b0;
    if (!fin) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          nw;
    logic [31:0] fw;

    vecs[0] = '{0, 0, 1, 0, 0, 0, 0, 16, 32'h3F80_0000};   // basic burst 1.0..16.0
    vecs[1] = '{0, 0, 1, 2, 6, 3, 0, 16, 32'h3F80_0000};   // 3-cycle hold mid-burst
    vecs[2] = '{0, 0, 1, 0, 0, 0, 5, 16, 32'h3F80_0000};   // start+write while busy
    vecs[3] = '{0, 0, 1, 0, 0, 0, 0, 16, 32'h3F80_0000};   // re-read: write was dropped
    vecs[4] = '{1, 3, 3, 0, 0, 0, 0, 48, 32'h4040_0000};   // wrap set3, set0, set1
    vecs[5] = '{0, 2, 16, 1, 0, 0, 0, 256, 32'h4000_0000}; // max bursts, random hold
    vecs[6] = '{0, 1, 5, 1, 0, 0, 7, 80, 32'h3F80_0000};   // random hold with injection
    vecs[7] = '{0, 3, 2, 2, 0, 2, 0, 32, 32'h4040_0000};   // hold together with start

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", move_buff_out, 32'd0);
    chk("rst_valid", {31'd0, move_buff_out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_valid", {31'd0, move_buff_out_valid}, 32'd0);
    end

    for (int a = 0; a < NSETS * DEPTH; a++) write_word(a, f32(a + 1));

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].prep != 0) begin
        for (int n = 0; n < NSETS; n++) write_word(n * DEPTH, f32(n));
      end
      run_cmd(vecs[v].set_s, vecs[v].nb, vecs[v].hmode, vecs[v].hfrom, vecs[v].hlen,
              vecs[v].inj, nw, fw);
      chk($sformatf("vec%0d_words", v), 32'(nw), 32'(vecs[v].exp_words));
      chk($sformatf("vec%0d_first", v), fw, vecs[v].exp_first);
    end

    // Random commands against the model.
    for (int r = 0; r < 4; r++) begin
      run_cmd(int'($urandom_range(0, NSETS - 1)), int'($urandom_range(1, 4)), 1, 0, 0, 0, nw, fw);
    end

    // burst_cnt == 0: done next cycle, never busy, no words.
    start = 1'b1; burst_cnt = '0; set_sel = '0;
    @(negedge clk);
    start = 1'b0;
    chk("noop_done", {31'd0, done}, 32'd1);
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_valid", {31'd0, move_buff_out_valid}, 32'd0);
    @(negedge clk);
    chk("noop_done_clr", {31'd0, done}, 32'd0);
    chk("noop_valid2", {31'd0, move_buff_out_valid}, 32'd0);

    // Asynchronous reset mid-burst.
    start = 1'b1; burst_cnt = BW'(2); set_sel = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", {31'd0, move_buff_out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, move_buff_out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wr_err", {31'd0, wr_err}, 32'd0);
    exp_wr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_valid", {31'd0, move_buff_out_valid}, 32'd0);
    end
    run_cmd(1, 2, 0, 0, 0, 0, nw, fw);
    chk("post_rst_words", 32'(nw), 32'd32);
    chk("post_rst_first", fw, 32'h3F80_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
